// File: rtl/id_inst_buffer.sv
// IF/ID instruction buffer: circular FIFO of {pc, inst} with a load-use interlock on the head
// and branch-flush handling that can keep the delay-slot instruction.
module id_inst_buffer #(
  parameter int DEPTH      = 4,
  parameter int PC_WD      = 32,
  parameter int INST_WD    = 32,
  parameter int LOAD_LAT   = 1,
  parameter int DELAY_SLOT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_WD-1:0]         in_pc,
  input  logic [INST_WD-1:0]       in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_WD-1:0]         out_pc,
  output logic [INST_WD-1:0]       out_inst,
  input  logic                     ex_is_load,
  input  logic [4:0]               ex_waddr,
  input  logic                     mem_is_load,
  input  logic [4:0]               mem_waddr,
  input  logic                     flush,
  output logic                     stallreq,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [PC_WD-1:0]   pc_mem   [DEPTH];
  logic [INST_WD-1:0] inst_mem [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          keep_slot_q, keep_slot_d;

  logic       nonempty, push, pop, flush_pop, wr_en;
  logic       h_ex, h_mem;
  logic [4:0] rs, rt;
  logic [INST_WD-1:0] head_inst;

  assign nonempty  = (count_q != '0);
  assign head_inst = inst_mem[rd_ptr_q];
  assign rs        = head_inst[25:21];
  assign rt        = head_inst[20:16];

  assign h_ex  = ex_is_load & (ex_waddr != 5'd0) & ((ex_waddr == rs) | (ex_waddr == rt));
  assign h_mem = (LOAD_LAT == 2) & mem_is_load & (mem_waddr != 5'd0) &
                 ((mem_waddr == rs) | (mem_waddr == rt));

  assign stallreq  = nonempty & (h_ex | h_mem);
  assign out_valid = nonempty & ~stallreq;
  assign in_ready  = (count_q != FULL_C);
  assign out_pc    = nonempty ? pc_mem[rd_ptr_q] : '0;
  assign out_inst  = nonempty ? head_inst : '0;
  assign count     = count_q;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign flush_pop = pop & flush;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    keep_slot_d = keep_slot_q;
    wr_en       = push;
    if (flush_pop) begin
      if (DELAY_SLOT == 0) begin
        rd_ptr_d    = wr_ptr_q;
        count_d     = '0;
        keep_slot_d = 1'b0;
        wr_en       = 1'b0;
      end else begin
        // The survivor always ends up at rd_ptr+1: either the queued entry there or,
        // with a single entry queued, the push landing at wr_ptr == rd_ptr+1.
        rd_ptr_d = rd_ptr_q + AW'(1);
        if (count_q >= CW'(2)) begin
          wr_ptr_d    = rd_ptr_q + AW'(2);
          count_d     = CW'(1);
          keep_slot_d = 1'b0;
          wr_en       = 1'b0;
        end else if (push) begin
          wr_ptr_d    = wr_ptr_q + AW'(1);
          count_d     = CW'(1);
          keep_slot_d = 1'b0;
        end else begin
          count_d     = '0;
          keep_slot_d = 1'b1;
        end
      end
    end else begin
      if (push) begin
        wr_ptr_d    = wr_ptr_q + AW'(1);
        keep_slot_d = 1'b0;
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      keep_slot_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      keep_slot_q <= keep_slot_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      pc_mem[wr_ptr_q]   <= in_pc;
      inst_mem[wr_ptr_q] <= in_inst;
    end
  end

endmodule

// File: tb/tb_id_inst_buffer.sv
// Bench for id_inst_buffer: two configurations share stimulus and are each checked
// against a queue-based reference model, plus directed scenarios.
module tb_id_inst_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, ex_is_load, mem_is_load, flush;
  logic [31:0] in_pc, in_inst;
  logic [4:0]  ex_waddr, mem_waddr;

  logic        a_in_ready, a_out_valid, a_stallreq;
  logic [31:0] a_out_pc, a_out_inst;
  logic [2:0]  a_count;
  logic        b_in_ready, b_out_valid, b_stallreq;
  logic [31:0] b_out_pc, b_out_inst;
  logic [2:0]  b_count;

  int n_checks = 0;
  int n_fail   = 0;

  ent_t q0[$];
  ent_t q1[$];
  ent_t cq[$];

  always #5 clk = ~clk;

  id_inst_buffer #(.DEPTH(DEPTH), .LOAD_LAT(1), .DELAY_SLOT(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
    .out_inst(a_out_inst), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr),
    .mem_is_load(mem_is_load), .mem_waddr(mem_waddr), .flush(flush),
    .stallreq(a_stallreq), .count(a_count));

  id_inst_buffer #(.DEPTH(DEPTH), .LOAD_LAT(2), .DELAY_SLOT(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
    .out_inst(b_out_inst), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr),
    .mem_is_load(mem_is_load), .mem_waddr(mem_waddr), .flush(flush),
    .stallreq(b_stallreq), .count(b_count));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic uses_reg(input logic [31:0] inst, input logic ld, input logic [4:0] wa);
    return ld && wa != 5'd0 && (wa == inst[25:21] || wa == inst[20:16]);
  endfunction

  // Compare one instance against the model in cq, then advance cq by one clock.
  task automatic model_check(input string nm, input int lat, input int ds,
                             input logic ir, input logic ov, input logic st,
                             input logic [31:0] opc, input logic [31:0] oinst,
                             input logic [2:0] cnt);
    int   n;
    logic h, push, pop;
    ent_t e;
    n = cq.size();
    h = 1'b0;
    if (n > 0) h = uses_reg(cq[0].inst, ex_is_load, ex_waddr) ||
                   (lat == 2 && uses_reg(cq[0].inst, mem_is_load, mem_waddr));
    chk({nm, ".count"}, cnt, n);
    chk({nm, ".in_ready"}, ir, n < DEPTH);
    chk({nm, ".stallreq"}, st, h);
    chk({nm, ".out_valid"}, ov, n > 0 && !h);
    chk({nm, ".out_pc"}, opc, (n > 0) ? cq[0].pc : 32'd0);
    chk({nm, ".out_inst"}, oinst, (n > 0) ? cq[0].inst : 32'd0);
    push   = in_valid && n < DEPTH;
    pop    = n > 0 && !h && out_ready;
    e.pc   = in_pc;
    e.inst = in_inst;
    if (pop && flush) begin
      if (ds == 0) cq.delete();
      else if (n >= 2) begin
        e = cq[1];
        cq.delete();
        cq.push_back(e);
      end else begin
        cq.delete();
        if (push) cq.push_back(e);
      end
    end else begin
      if (pop) void'(cq.pop_front());
      if (push) cq.push_back(e);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      cq = q0;
      model_check("a", 1, 1, a_in_ready, a_out_valid, a_stallreq, a_out_pc, a_out_inst, a_count);
      q0 = cq;
      cq = q1;
      model_check("b", 2, 0, b_in_ready, b_out_valid, b_stallreq, b_out_pc, b_out_inst, b_count);
      q1 = cq;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                        input logic ordy, input logic fl);
    in_valid    = iv;
    in_pc       = pc;
    in_inst     = inst;
    out_ready   = ordy;
    flush       = fl;
    ex_is_load  = 1'b0;
    ex_waddr    = 5'd0;
    mem_is_load = 1'b0;
    mem_waddr   = 5'd0;
  endtask

  task automatic drain();
    set_in(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    for (int k = 0; k < 20 && (q0.size() != 0 || q1.size() != 0); k++) step();
    chk("drain_a", a_count, 0);
    chk("drain_b", b_count, 0);
  endtask

  initial begin
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst.in_ready", a_in_ready, 1);
    chk("rst.out_valid", a_out_valid, 0);
    chk("rst.out_pc", a_out_pc, 0);
    chk("rst.count", b_count, 0);

    // fill then drain in order
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 32'h100 + 32'(4 * k), 32'h0000_1000 + 32'(k), 1'b0, 1'b0);
      step();
    end
    chk("fill.count", a_count, 4);
    chk("fill.in_ready", a_in_ready, 0);
    set_in(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("drain.pc", a_out_pc, 32'h100 + 32'(4 * k));
      step();
    end
    chk("drain.count", a_count, 0);

    // concurrent push/pop across pointer wrap
    for (int k = 0; k < 10; k++) begin
      set_in(1'b1, 32'h400 + 32'(4 * k), 32'h0000_2000 + 32'(k), 1'b1, 1'b0);
      step();
    end
    chk("wrap.count", a_count, 1);
    chk("wrap.pc", a_out_pc, 32'h424);
    drain();

    // load-use interlock
    set_in(1'b1, 32'h300, 32'h0085_1021, 1'b0, 1'b0);
    step();
    set_in(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    ex_is_load = 1'b1;
    ex_waddr   = 5'd5;
    #1;
    chk("lu.stall", a_stallreq, 1);
    chk("lu.out_valid", a_out_valid, 0);
    step();
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    chk("lu.release", a_out_valid, 1);
    chk("lu.same_head", a_out_inst, 32'h0085_1021);
    step();
    ex_is_load = 1'b1;
    ex_waddr   = 5'd0;
    #1;
    chk("lu.r0", a_stallreq, 0);
    step();
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    mem_is_load = 1'b1;
    mem_waddr   = 5'd4;
    #1;
    chk("lu.mem_lat1", a_stallreq, 0);
    chk("lu.mem_lat2", b_stallreq, 1);
    step();
    drain();

    // delay slot with queued successor
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 32'h200 + 32'(4 * k), 32'h1000_0000 + 32'(k), 1'b0, 1'b0);
      step();
    end
    set_in(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
    step();
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("ds.count", a_count, 1);
    chk("ds.pc", a_out_pc, 32'h204);
    chk("ds0.count", b_count, 0);
    step();
    drain();

    // delay slot pending on next push
    set_in(1'b1, 32'h200, 32'h1000_0000, 1'b0, 1'b0);
    step();
    set_in(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
    step();
    chk("dsp.count", a_count, 0);
    chk("dsp0.count", b_count, 0);
    set_in(1'b1, 32'h204, 32'h0000_0001, 1'b0, 1'b0);
    step();
    chk("dsp.kept", a_count, 1);
    chk("dsp.kept_pc", a_out_pc, 32'h204);
    drain();

    // randomized traffic with a mid-run reset
    for (int i = 0; i < 600; i++) begin
      logic [31:0] inst;
      inst = {6'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      set_in(($urandom % 4) != 0, 32'h1000 + 32'(4 * i), inst,
             ($urandom % 8) < ((i / 100) % 2 == 0 ? 3 : 6), ($urandom % 8) == 0);
      ex_is_load  = ($urandom % 3) == 0;
      ex_waddr    = 5'($urandom_range(0, 7));
      mem_is_load = ($urandom % 3) == 0;
      mem_waddr   = 5'($urandom_range(0, 7));
      rst         = (i == 350);
      step();
    end
    rst = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
